clk_monitor: RTL



---
 rtl/clk_monitor_pkg.sv | 19 +
 rtl/clk_monitor_sync_edge_det.sv | 39 +++
 rtl/clk_monitor.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/clk_monitor_pkg.sv
// clk_monitor_pkg: shared types and constants for the clock monitor.
//   mon_state_e : monitor FSM states
//   CLK0_HZ     : frequency of the clk0 domain the monitor runs in
//   win_width() : bit width needed for a window counter running 0..window-1
package clk_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_EVAL    = 2'd2
  } mon_state_e;

  localparam int unsigned CLK0_HZ = 32_000_000;

  function automatic int win_width(input int window);
    return (window > 1) ? $clog2(window) : 1;
  endfunction

endpackage

// File: rtl/clk_monitor_sync_edge_det.sv
// sync_edge_det: two-flop synchroniser followed by an edge register, for any
// asynchronous single-bit input (monitored clocks, MIDI, buttons).
// Ports:
//   clk   in  sampling clock
//   rst_n in  asynchronous active-low reset
//   d_in  in  asynchronous input
//   rise  out high for one clk cycle per synchronised rising edge
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic last_q, last_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
    last_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end

  assign rise = sync_q & ~last_q;

endmodule

// File: rtl/clk_monitor.sv
// clk_monitor: counts rising edges of an asynchronous divided clock over a
// fixed clk0 window, checks the count against EXPECTED +/- TOL and declares
// lock after LOCK_WINDOWS consecutive good windows. A bad window while locked
// raises a sticky fault.
// Optional: define CLK_MON_STUCK_EN to add a stuck-clock detector that faults
// after STUCK_CYCLES clk0 cycles with no detected edge.
// Ports:
//   clk0       in  system clock
//   rst_n      in  asynchronous active-low reset
//   mon_clk    in  monitored clock, asynchronous to clk0
//   enable     in  run the monitor (level)
//   clr_fault  in  pulse: clear sticky fault
//   meas_count out edge count of the last completed window
//   meas_valid out one-cycle pulse when meas_count updates
//   in_range   out last window within EXPECTED +/- TOL
//   locked     out LOCK_WINDOWS consecutive good windows seen
//   fault      out sticky fault
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | disabled, counters held at 0
// MEASURE  | window counter running, detected edges counted
// EVAL     | one cycle: publish count, update in_range / lock / fault
module clk_monitor
  import clk_monitor_pkg::*;
#(
  parameter int WINDOW       = 3200,
  parameter int EXPECTED     = 100,
  parameter int TOL          = 2,
  parameter int LOCK_WINDOWS = 4,
  parameter int CNT_W        = 16
`ifdef CLK_MON_STUCK_EN
  ,
  parameter int STUCK_CYCLES = 256
`endif
) (
  input  logic             clk0,
  input  logic             rst_n,
  input  logic             mon_clk,
  input  logic             enable,
  input  logic             clr_fault,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic             in_range,
  output logic             locked,
  output logic             fault
);

  localparam int WIN_W  = win_width(WINDOW);
  localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);
  localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [GOOD_W-1:0]    LOCK_CNT = GOOD_W'(LOCK_WINDOWS);
  localparam logic signed [CNT_W:0] EXP_S   = (CNT_W + 1)'(EXPECTED);
  localparam logic signed [CNT_W:0] TOL_S   = (CNT_W + 1)'(TOL);

  mon_state_e        state_q, state_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0]  meas_count_q, meas_count_d;
  logic              meas_valid_q, meas_valid_d;
  logic              in_range_q, in_range_d;
  logic              locked_q, locked_d;
  logic              fault_q, fault_d;

  logic              rise;
  logic signed [CNT_W:0] diff, diff_abs;
  logic              win_ok;

  sync_edge_det u_sync (
    .clk   (clk0),
    .rst_n (rst_n),
    .d_in  (mon_clk),
    .rise  (rise)
  );

  // Signed difference one bit wider than the counter so a saturated count
  // cannot wrap into the tolerance band.
  always_comb begin
    diff     = $signed({1'b0, edge_cnt_q}) - EXP_S;
    diff_abs = diff[CNT_W] ? -diff : diff;
    win_ok   = (diff_abs <= TOL_S);
  end

`ifdef CLK_MON_STUCK_EN
  localparam int STUCK_W = (STUCK_CYCLES > 1) ? $clog2(STUCK_CYCLES) : 1;
  localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_CYCLES - 1);
  logic [STUCK_W-1:0] stuck_cnt_q, stuck_cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    win_cnt_d    = win_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    good_cnt_d   = good_cnt_q;
    meas_count_d = meas_count_q;
    meas_valid_d = 1'b0;
    in_range_d   = in_range_q;
    locked_d     = locked_q;
    fault_d      = fault_q & ~clr_fault;

    case (state_q)
      ST_IDLE: begin
        win_cnt_d  = '0;
        edge_cnt_d = '0;
        good_cnt_d = '0;
        locked_d   = 1'b0;
        if (enable) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (!enable) begin
          state_d    = ST_IDLE;
          win_cnt_d  = '0;
          edge_cnt_d = '0;
          good_cnt_d = '0;
          locked_d   = 1'b0;
        end else begin
          if (rise && (edge_cnt_q != {CNT_W{1'b1}})) edge_cnt_d = edge_cnt_q + 1'b1;
          if (win_cnt_q == WIN_LAST) state_d = ST_EVAL;
          else                       win_cnt_d = win_cnt_q + 1'b1;
        end
      end
      ST_EVAL: begin
        // Edges detected in this cycle are intentionally not counted.
        meas_count_d = edge_cnt_q;
        meas_valid_d = 1'b1;
        in_range_d   = win_ok;
        if (win_ok) good_cnt_d = (good_cnt_q == LOCK_CNT) ? good_cnt_q : good_cnt_q + 1'b1;
        else        good_cnt_d = '0;
        locked_d = (good_cnt_d == LOCK_CNT);
        if (!win_ok && locked_q) fault_d = 1'b1;
        win_cnt_d  = '0;
        edge_cnt_d = '0;
        state_d    = enable ? ST_MEASURE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef CLK_MON_STUCK_EN
    stuck_cnt_d = stuck_cnt_q;
    if ((state_q == ST_IDLE) || (state_d == ST_IDLE) || rise) begin
      stuck_cnt_d = '0;
    end else if (stuck_cnt_q == STUCK_LAST) begin
      // Abandon the window without publishing and restart measuring.
      stuck_cnt_d  = '0;
      fault_d      = 1'b1;
      locked_d     = 1'b0;
      good_cnt_d   = '0;
      win_cnt_d    = '0;
      edge_cnt_d   = '0;
      meas_valid_d = 1'b0;
      meas_count_d = meas_count_q;
      in_range_d   = in_range_q;
      state_d      = ST_MEASURE;
    end else begin
      stuck_cnt_d = stuck_cnt_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      win_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      good_cnt_q   <= '0;
      meas_count_q <= '0;
      meas_valid_q <= 1'b0;
      in_range_q   <= 1'b0;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      good_cnt_q   <= good_cnt_d;
      meas_count_q <= meas_count_d;
      meas_valid_q <= meas_valid_d;
      in_range_q   <= in_range_d;
      locked_q     <= locked_d;
      fault_q      <= fault_d;
    end
  end

`ifdef CLK_MON_STUCK_EN
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) stuck_cnt_q <= '0;
    else        stuck_cnt_q <= stuck_cnt_d;
  end
`endif

  assign meas_count = meas_count_q;
  assign meas_valid = meas_valid_q;
  assign in_range   = in_range_q;
  assign locked     = locked_q;
  assign fault      = fault_q;

endmodule
